// File: rtl/upsampling_line_sequencer.sv
// upsampling_line_sequencer
//   Line/frame controller sitting between the input DMA stream and the
//   upsampler's s00_axis port. It passes input beats through one line at a
//   time and generates the upsampler tlast from the configured word count.
//   The upstream tlast is only checked, never used to realign the stream.
//   It inserts a programmable idle gap after each line. It also counts the
//   upsampler's output lines (two per input line) to limit how many input
//   lines are in flight, and it pulses done once the frame has fully drained.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_words_per_line  words per input line (sampled on start)
//   cfg_lines           input lines per frame (sampled on start)
//   cfg_gap             idle cycles after each non-final line (sampled on start)
//   start, abort        frame start pulse (IDLE only) / synchronous abort
//   s_*                 upstream AXI-stream slave (s_tlast checked only)
//   u_*                 stream towards the upsampler s00_axis
//   o_tvalid/tready/tlast  upsampler m00_axis, monitored only
//   busy, done          not-IDLE flag / one-cycle frame completion pulse
//   err_tlast_early     sticky: s_tlast seen on a non-final beat
//   err_tlast_missing   sticky: s_tlast missing on the final beat
//   line_cnt            input lines completed in the current frame
module upsampling_line_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_W     = 16,
  parameter int FRAME_W    = 12,
  parameter int GAP_W      = 8,
  parameter int MAX_AHEAD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_W-1:0]     cfg_words_per_line,
  input  logic [FRAME_W-1:0]    cfg_lines,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] u_tdata,
  output logic                  u_tvalid,
  input  logic                  u_tready,
  output logic                  u_tlast,
  input  logic                  o_tvalid,
  input  logic                  o_tready,
  input  logic                  o_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  err_tlast_early,
  output logic                  err_tlast_missing,
  output logic [FRAME_W-1:0]    line_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINE,
    ST_GAP,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  localparam logic [FRAME_W:0] AHEAD = (FRAME_W+1)'(MAX_AHEAD);

  state_t               state;
  state_t               state_next;
  logic                 done_next;

  logic [LINE_W-1:0]    words_r;
  logic [FRAME_W-1:0]   lines_r;
  logic [GAP_W-1:0]     gap_r;
  logic [LINE_W-1:0]    word_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [FRAME_W:0]     in_flight;
  logic [FRAME_W:0]     in_flight_inc;
  logic                 half;

  logic                 in_line;
  logic                 beat;
  logic                 last_word;
  logic                 line_end;
  logic                 final_line;
  logic                 gap_last;
  logic                 out_line;
  logic                 out_accept;
  logic                 out_dec;
  logic                 cfg_ok;
  logic                 start_go;

  assign in_line       = (state == ST_LINE);
  assign last_word     = (word_cnt == (words_r - LINE_W'(1)));
  assign beat          = in_line & s_tvalid & u_tready;
  assign line_end      = beat & last_word;
  assign final_line    = ((line_cnt + FRAME_W'(1)) == lines_r);
  assign gap_last      = (gap_cnt == (gap_r - GAP_W'(1)));
  assign in_flight_inc = in_flight + (FRAME_W+1)'(1);

  // Output lines arriving while nothing is in flight are ignored entirely,
  // so they do not disturb the half-line phase either.
  assign out_line   = o_tvalid & o_tready & o_tlast;
  assign out_accept = out_line & (in_flight != '0);
  assign out_dec    = out_accept & half;

  assign cfg_ok   = (cfg_words_per_line != '0) && (cfg_lines != '0);
  assign start_go = (state == ST_IDLE) & start & ~abort & cfg_ok;

  // Zero-latency datapath, open only while a line is being transferred.
  assign u_tdata  = in_line ? s_tdata : '0;
  assign u_tvalid = in_line & s_tvalid;
  assign s_tready = in_line & u_tready;
  assign u_tlast  = in_line & last_word;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) state_next = ST_LINE;
            else        done_next  = 1'b1;
          end
        end
        ST_LINE: begin
          if (line_end) begin
            if (final_line)               state_next = ST_DRAIN;
            else if (gap_r != '0)         state_next = ST_GAP;
            else if (in_flight_inc >= AHEAD) state_next = ST_WAIT;
          end
        end
        ST_GAP: begin
          if (gap_last) state_next = (in_flight >= AHEAD) ? ST_WAIT : ST_LINE;
        end
        ST_WAIT: begin
          if (in_flight < AHEAD) state_next = ST_LINE;
        end
        ST_DRAIN: begin
          if (in_flight == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_r   <= '0;
      lines_r   <= '0;
      gap_r     <= '0;
      word_cnt  <= '0;
      line_cnt  <= '0;
      gap_cnt   <= '0;
      in_flight <= '0;
      half      <= 1'b0;
    end else if (abort) begin
      word_cnt  <= '0;
      line_cnt  <= '0;
      gap_cnt   <= '0;
      in_flight <= '0;
      half      <= 1'b0;
    end else if (start_go) begin
      words_r   <= cfg_words_per_line;
      lines_r   <= cfg_lines;
      gap_r     <= cfg_gap;
      word_cnt  <= '0;
      line_cnt  <= '0;
      gap_cnt   <= '0;
      in_flight <= '0;
      half      <= 1'b0;
    end else begin
      if (beat) word_cnt <= last_word ? '0 : word_cnt + LINE_W'(1);
      if (line_end) line_cnt <= line_cnt + FRAME_W'(1);

      // A completed input line and a completed output pair in the same
      // cycle cancel out.
      if (line_end && !out_dec)      in_flight <= in_flight_inc;
      else if (!line_end && out_dec) in_flight <= in_flight - (FRAME_W+1)'(1);

      if (out_accept) half <= ~half;

      if (state == ST_GAP) gap_cnt <= gap_last ? '0 : gap_cnt + GAP_W'(1);
      else                 gap_cnt <= '0;
    end
  end

  // Error flags survive abort; beats accepted in an abort cycle are still
  // checked because they still reach the upsampler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else if (start_go) begin
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else if (beat) begin
      if (s_tlast && !last_word) err_tlast_early   <= 1'b1;
      if (!s_tlast && last_word) err_tlast_missing <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upsampling_line_sequencer.sv
module tb_upsampling_line_sequencer;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FW = 12;
  localparam int GW = 8;
  localparam int MA = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_words_per_line;
  logic [FW-1:0] cfg_lines;
  logic [GW-1:0] cfg_gap;
  logic          start;
  logic          abort;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] u_tdata;
  logic          u_tvalid;
  logic          u_tready;
  logic          u_tlast;
  logic          o_tvalid;
  logic          o_tready;
  logic          o_tlast;
  logic          busy;
  logic          done;
  logic          err_tlast_early;
  logic          err_tlast_missing;
  logic [FW-1:0] line_cnt;

  always #5 clk = ~clk;

  upsampling_line_sequencer #(
    .DATA_WIDTH(DW),
    .LINE_W    (LW),
    .FRAME_W   (FW),
    .GAP_W     (GW),
    .MAX_AHEAD (MA)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_words_per_line(cfg_words_per_line),
    .cfg_lines         (cfg_lines),
    .cfg_gap           (cfg_gap),
    .start             (start),
    .abort             (abort),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .s_tlast           (s_tlast),
    .u_tdata           (u_tdata),
    .u_tvalid          (u_tvalid),
    .u_tready          (u_tready),
    .u_tlast           (u_tlast),
    .o_tvalid          (o_tvalid),
    .o_tready          (o_tready),
    .o_tlast           (o_tlast),
    .busy              (busy),
    .done              (done),
    .err_tlast_early   (err_tlast_early),
    .err_tlast_missing (err_tlast_missing),
    .line_cnt          (line_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: beats accepted, lines completed, output lines
  // counted; lines in flight = lines - floor(outputs / 2).
  int m_words, m_lines, m_gap;
  bit m_active;
  int m_beats, m_lcnt, m_outs, m_since;
  bit m_err_e, m_err_m, m_zero_done;
  int m_done_wait, m_done_cnt, m_tlast_cnt;

  // Stimulus knobs
  int k_pvalid = 100, k_pready = 100, k_omode = 0;
  int k_flip0 = -1, k_flip1 = -1;
  bit k_noise = 0, k_exact_gap = 0;

  function automatic int m_infl();
    return m_lcnt - m_outs / 2;
  endfunction

  function automatic bit m_complete();
    return m_active && (m_beats == m_words * m_lines) && (m_infl() == 0);
  endfunction

  task automatic model_clear();
    m_active = 0; m_beats = 0; m_lcnt = 0; m_outs = 0;
    m_since = 1000; m_done_wait = 0;
  endtask

  task automatic drive();
    bit outstanding;
    start    = 1'b0;
    abort    = 1'b0;
    s_tvalid = ($urandom_range(99) < k_pvalid);
    u_tready = ($urandom_range(99) < k_pready);
    s_tdata  = $urandom;
    s_tlast  = 1'b0;
    if (m_active && m_words != 0) begin
      s_tlast = ((m_beats % m_words) == m_words - 1);
      if (m_beats == k_flip0 || m_beats == k_flip1) s_tlast = ~s_tlast;
    end
    outstanding = m_active && (2 * m_lcnt > m_outs);
    case (k_omode)
      1: begin o_tvalid = 1'b1; o_tready = 1'b1; o_tlast = outstanding; end
      2: begin
        o_tvalid = ($urandom_range(9) < 7);
        o_tready = ($urandom_range(9) < 7);
        o_tlast  = ($urandom_range(1) == 1);
      end
      default: begin o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0; end
    endcase
    if (k_noise && m_active) begin
      cfg_words_per_line = LW'($urandom);
      cfg_lines          = FW'($urandom);
      cfg_gap            = GW'($urandom);
      if (!m_complete() && $urandom_range(49) == 0) start = 1'b1;
    end
  endtask

  task automatic sample_and_account();
    int  total, lcnt_pre;
    bit  cmpl, exp_last;
    total    = m_words * m_lines;
    cmpl     = m_complete();
    lcnt_pre = m_lcnt;
    check("line_cnt", line_cnt, m_lcnt);
    check("err_early", err_tlast_early, m_err_e);
    check("err_missing", err_tlast_missing, m_err_m);
    if (!m_active) begin
      check("busy_idle", busy, 0);
      check("s_tready_idle", s_tready, 0);
      check("u_tvalid_idle", u_tvalid, 0);
      check("u_tlast_idle", u_tlast, 0);
      check("done_idle", done, m_zero_done);
    end else begin
      if (!cmpl) begin
        check("busy", busy, 1);
        check("done_early", done, 0);
      end else if (!done) begin
        check("busy_drain", busy, 1);
        m_done_wait++;
        if (m_done_wait == 5) check("done_latency", done, 1);
      end
      if (!u_tready) check("s_tready_bp", s_tready, 0);
      if (m_beats == total || m_infl() >= MA || m_since < m_gap)
        check("s_tready_hold", s_tready, 0);
      else if (k_exact_gap && m_since == m_gap && u_tready)
        check("gap_release", s_tready, 1);
      if (s_tready) check("u_tvalid", u_tvalid, s_tvalid);
      if (u_tvalid) check("u_tdata", u_tdata, s_tdata);
      if (u_tvalid && u_tready && m_beats < total) begin
        exp_last = ((m_beats % m_words) == m_words - 1);
        check("u_tlast", u_tlast, exp_last);
        if (u_tlast) m_tlast_cnt++;
        if (s_tlast && !exp_last) m_err_e = 1;
        if (!s_tlast && exp_last) m_err_m = 1;
        m_beats++;
        if (m_since < 1000) m_since++;
        if (exp_last) begin
          m_lcnt++;
          if (m_lcnt < m_lines) m_since = 0;
        end
      end else if (m_since < 1000) begin
        m_since++;
      end
      if (o_tvalid && o_tready && o_tlast && 2 * lcnt_pre > m_outs) m_outs++;
      if (done) begin
        check("busy_at_done", busy, 0);
        m_active = 0;
        m_done_cnt++;
      end
    end
    m_zero_done = 0;
    if (abort) begin
      model_clear();
    end else if (start && !m_active) begin
      if (cfg_words_per_line != 0 && cfg_lines != 0) begin
        model_clear();
        m_words  = int'(cfg_words_per_line);
        m_lines  = int'(cfg_lines);
        m_gap    = int'(cfg_gap);
        m_active = 1;
        m_err_e  = 0;
        m_err_m  = 0;
      end else begin
        m_zero_done = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_account();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_frame(input int w, input int l, input int g, input int budget);
    int d0, n;
    cfg_words_per_line = LW'(w);
    cfg_lines          = FW'(l);
    cfg_gap            = GW'(g);
    start              = 1'b1;
    d0 = m_done_cnt;
    m_tlast_cnt = 0;
    n = 0;
    cycle();
    while (m_done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check("frame_done", m_done_cnt - d0, 1);
    if (m_done_cnt == d0) begin
      abort = 1'b1;
      cycle();
    end else begin
      check("u_tlast_count", m_tlast_cnt, l);
    end
    repeat (3) cycle();
  endtask

  initial begin
    int n, d0, rel;
    model_clear();
    m_words = 0; m_lines = 0; m_gap = 0;
    m_err_e = 0; m_err_m = 0; m_zero_done = 0;
    m_done_cnt = 0; m_tlast_cnt = 0;
    cfg_words_per_line = '0; cfg_lines = '0; cfg_gap = '0;
    rst = 1'b1;
    drive();
    s_tvalid = 1'b1;
    u_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_u_tvalid", u_tvalid, 0);
    check("rst_u_tlast", u_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_errs", {err_tlast_early, err_tlast_missing}, 0);
    rst = 1'b0;

    // Two long lines, no gap, output lines returned promptly
    k_omode = 1;
    run_frame(600, 2, 0, 5000);

    // Exact inter-line gap
    k_exact_gap = 1;
    run_frame(8, 3, 5, 500);
    k_exact_gap = 0;

    // Lines-in-flight limit with no output lines returned
    k_omode = 0;
    cfg_words_per_line = 16'd4; cfg_lines = 12'd4; cfg_gap = 8'd0;
    start = 1'b1;
    d0 = m_done_cnt;
    m_tlast_cnt = 0;
    cycle();
    n = 0;
    while (m_lcnt < 2 && n < 100) begin cycle(); n++; end
    repeat (4) cycle();
    check("wait_hold", s_tready, 0);
    o_tvalid = 1'b1; o_tready = 1'b1; o_tlast = 1'b1;
    cycle();
    repeat (4) cycle();
    check("wait_half", s_tready, 0);
    o_tvalid = 1'b1; o_tready = 1'b1; o_tlast = 1'b1;
    cycle();
    rel = -1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (s_tready && rel < 0) rel = i;
    end
    check("wait_release", rel, 0);
    k_omode = 1;
    n = 0;
    while (m_done_cnt == d0 && n < 300) begin cycle(); n++; end
    check("wait_frame_done", m_done_cnt - d0, 1);
    check("wait_tlast_count", m_tlast_cnt, 4);
    repeat (3) cycle();

    // Upstream tlast early on beat 300 and missing on beat 600
    k_flip0 = 299; k_flip1 = 599;
    run_frame(600, 1, 0, 3000);
    check("err_early_set", err_tlast_early, 1);
    check("err_missing_set", err_tlast_missing, 1);
    k_flip0 = -1; k_flip1 = -1;

    // Abort mid-line (start in the same cycle is overridden)
    k_omode = 2;
    cfg_words_per_line = 16'd600; cfg_lines = 12'd2; cfg_gap = 8'd0;
    start = 1'b1;
    cycle();
    check("err_clear_on_start", {err_tlast_early, err_tlast_missing}, 0);
    n = 0;
    while (m_beats < 250 && n < 2000) begin cycle(); n++; end
    abort = 1'b1;
    start = 1'b1;
    cycle();
    check("abort_s_tready", s_tready, 0);
    check("abort_busy", busy, 0);
    check("abort_line_cnt", line_cnt, 0);
    repeat (5) cycle();
    run_frame(600, 2, 0, 5000);

    // Reset mid-line, then a zero-line start
    cfg_words_per_line = 16'd600; cfg_lines = 12'd2; cfg_gap = 8'd0;
    start = 1'b1;
    repeat (100) cycle();
    s_tvalid = 1'b1;
    u_tready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_s_tready", s_tready, 0);
    check("arst_u_tvalid", u_tvalid, 0);
    check("arst_u_tdata", u_tdata, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    model_clear();
    m_err_e = 0; m_err_m = 0; m_zero_done = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    cfg_words_per_line = 16'd600; cfg_lines = 12'd0;
    start = 1'b1;
    cycle();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    repeat (3) cycle();

    // Randomized frames with backpressure, spurious output tlasts,
    // mid-frame config changes and ignored start pulses
    k_omode = 2;
    for (int f = 0; f < 6; f++) begin
      k_pvalid = int'($urandom_range(40, 100));
      k_pready = int'($urandom_range(40, 100));
      k_noise  = 1;
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 4)), 4000);
      k_noise  = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
